// File: rtl/sfifo_sch_pkg.sv
// Shared definitions for the FIFO read schedulers: FSM encoding, default burst length
// and a constant-width helper.
package sfifo_sch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARB   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    localparam int BURST_MAX_DEF = 4;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_arb_cbb.sv
// Round-robin picker: grants the first requester at or after ptr+1 (mod N),
// returning both a one-hot grant and the encoded index.
module rr_arb_cbb #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] qid,
    output logic         vld
);
    logic [W-1:0] start;
    logic [N-1:0] req_rot;
    logic [W-1:0] off;
    logic [W:0]   sum;

    always_comb begin
        start   = (ptr == W'(N - 1)) ? '0 : ptr + W'(1);
        req_rot = N'({req, req} >> start);
        off     = '0;
        vld     = 1'b0;
        // Descending scan so the lowest rotated index (closest to start) wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                off = W'(k);
                vld = 1'b1;
            end
        end
        sum = {1'b0, start} + {1'b0, off};
        qid = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
        gnt = vld ? (N'(1) << qid) : '0;
    end

endmodule

// File: rtl/sfifo_rr_sch.sv
// Round-robin read scheduler draining QUEUE_NUM FIFOs into one tagged write stream.
// Optional per-queue burst weights: define SFIFO_RR_SCH_WEIGHT_EN.
//
// state    | meaning
// ST_IDLE  | nothing granted, waiting for a request with downstream room
// ST_ARB   | one-cycle pick of the next queue, latch its burst limit
// ST_BURST | reading the granted queue until limit reached or it runs dry
module sfifo_rr_sch
    import sfifo_sch_pkg::*;
#(
    parameter int QUEUE_NUM = 4,
    parameter int QID_W     = 2,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    input  logic [QUEUE_NUM-1:0]        fifo_empty,
    output logic [QUEUE_NUM-1:0]        fifo_ren,
    input  logic [QUEUE_NUM*DATA_W-1:0] fifo_rdata,
    input  logic                        out_afull,
    output logic                        out_wen,
    output logic [DATA_W-1:0]           out_wdata,
    output logic [QID_W-1:0]            out_qid,
`ifdef SFIFO_RR_SCH_WEIGHT_EN
    input  logic [QUEUE_NUM*8-1:0]      cfg_weight,
`endif
    output logic                        sch_busy
);
    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

    logic [1:0]           state, state_nxt;
    logic [QID_W-1:0]     ptr, gnt_qid, arb_qid;
    logic [QUEUE_NUM-1:0] req, arb_gnt;
    logic [7:0]           lim_q [QUEUE_NUM];
    logic [7:0]           burst_cnt, burst_lim, arb_lim;
    logic                 arb_vld, gnt_empty, issue, wake, burst_exit;
    logic [RD_LAT-1:0]    pipe_vld;
    logic [QID_W-1:0]     pipe_qid [RD_LAT];

    // A zero limit removes the queue from arbitration entirely.
    always_comb begin
        for (int i = 0; i < QUEUE_NUM; i++) begin
`ifdef SFIFO_RR_SCH_WEIGHT_EN
            lim_q[i] = cfg_weight[i*8 +: 8];
`else
            lim_q[i] = BURST_LIM;
`endif
            req[i] = ~fifo_empty[i] & (lim_q[i] != 8'd0);
        end
    end

    rr_arb_cbb #(.N(QUEUE_NUM), .W(QID_W)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .qid (arb_qid),
        .vld (arb_vld)
    );

    always_comb begin
        arb_lim   = BURST_LIM;
        gnt_empty = 1'b1;
        for (int i = 0; i < QUEUE_NUM; i++) begin
            if (arb_gnt[i]) arb_lim = lim_q[i];
            if (gnt_qid == QID_W'(i)) gnt_empty = fifo_empty[i];
        end
    end

    assign issue      = (state == ST_BURST) & ~gnt_empty & ~out_afull;
    assign wake       = (|req) & ~out_afull;
    assign burst_exit = (state == ST_BURST) &
                        ((issue & (burst_cnt + 8'd1 == burst_lim)) | gnt_empty);

    always_comb begin
        for (int i = 0; i < QUEUE_NUM; i++) fifo_ren[i] = issue & (gnt_qid == QID_W'(i));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (wake) state_nxt = ST_ARB;
            ST_ARB:   state_nxt = arb_vld ? ST_BURST : ST_IDLE;
            ST_BURST: if (burst_exit) state_nxt = wake ? ST_ARB : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            gnt_qid   <= '0;
            burst_cnt <= '0;
            burst_lim <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_ARB) begin
                gnt_qid   <= arb_qid;
                burst_cnt <= '0;
                burst_lim <= arb_lim;
            end else if (issue) begin
                burst_cnt <= burst_cnt + 8'd1;
            end
            if (burst_exit) ptr <= gnt_qid;
        end
    end

    // Issue tags ride alongside the FIFO read latency; reset drops anything in flight.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_qid[i] <= '0;
        end else begin
            pipe_vld[0] <= issue;
            pipe_qid[0] <= gnt_qid;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_qid[i] <= pipe_qid[i-1];
            end
        end
    end

    always_comb begin
        out_wen   = pipe_vld[RD_LAT-1];
        out_qid   = out_wen ? pipe_qid[RD_LAT-1] : '0;
        out_wdata = '0;
        for (int i = 0; i < QUEUE_NUM; i++) begin
            if (out_wen && (pipe_qid[RD_LAT-1] == QID_W'(i)))
                out_wdata = fifo_rdata[i*DATA_W +: DATA_W];
        end
    end

    assign sch_busy = (state != ST_IDLE) | (|pipe_vld);

endmodule

// File: tb/tb_sfifo_rr_sch.sv
// Directed bench for sfifo_rr_sch: one instance at RD_LAT=1, one at RD_LAT=2,
// each fed by a behavioural FIFO bank whose word k of queue q is q*32+k.
module tb_sfifo_rr_sch;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset;
    logic [3:0]  empty_v [2];
    logic [3:0]  ren_v   [2];
    logic [31:0] rdata_v [2];
    logic        afull_v [2];
    logic        wen_v   [2];
    logic [7:0]  wdata_v [2];
    logic [1:0]  qid_v   [2];
    logic        busy_v  [2];
`ifdef SFIFO_RR_SCH_WEIGHT_EN
    logic [31:0] cfg_weight;
`endif

    sfifo_rr_sch #(.QUEUE_NUM(4), .QID_W(2), .DATA_W(8), .RD_LAT(1), .BURST_MAX(4)) dut1 (
        .clk_sys(clk_sys), .reset(reset), .fifo_empty(empty_v[0]), .fifo_ren(ren_v[0]),
        .fifo_rdata(rdata_v[0]), .out_afull(afull_v[0]), .out_wen(wen_v[0]),
        .out_wdata(wdata_v[0]), .out_qid(qid_v[0]),
`ifdef SFIFO_RR_SCH_WEIGHT_EN
        .cfg_weight(cfg_weight),
`endif
        .sch_busy(busy_v[0]));

    sfifo_rr_sch #(.QUEUE_NUM(4), .QID_W(2), .DATA_W(8), .RD_LAT(2), .BURST_MAX(4)) dut2 (
        .clk_sys(clk_sys), .reset(reset), .fifo_empty(empty_v[1]), .fifo_ren(ren_v[1]),
        .fifo_rdata(rdata_v[1]), .out_afull(afull_v[1]), .out_wen(wen_v[1]),
        .out_wdata(wdata_v[1]), .out_qid(qid_v[1]),
`ifdef SFIFO_RR_SCH_WEIGHT_EN
        .cfg_weight(cfg_weight),
`endif
        .sch_busy(busy_v[1]));

    // FIFO bank model: wr_cnt is owned by the stimulus, rd_cnt by the model.
    int         wr_cnt [2][4];
    int         rd_cnt [2][4];
    logic [7:0] s1 [2][4];
    logic [7:0] s2 [2][4];

    function automatic logic [7:0] word(input int q, input int k);
        return 8'((q * 32) + (k & 31));
    endfunction

    always @(posedge clk_sys) begin
        for (int u = 0; u < 2; u++) begin
            for (int q = 0; q < 4; q++) begin
                if (ren_v[u][q]) begin
                    rd_cnt[u][q] <= rd_cnt[u][q] + 1;
                    s1[u][q]     <= word(q, rd_cnt[u][q]);
                end
                s2[u][q] <= s1[u][q];
            end
        end
    end

    always_comb begin
        for (int u = 0; u < 2; u++) begin
            empty_v[u] = '0;
            rdata_v[u] = '0;
            for (int q = 0; q < 4; q++) begin
                empty_v[u][q]       = (rd_cnt[u][q] == wr_cnt[u][q]);
                rdata_v[u][q*8 +: 8] = (u == 0) ? s1[u][q] : s2[u][q];
            end
        end
    end

    // Stream recorder, sampled mid-cycle.
    int         cyc;
    int         ren_n [2];
    int         ren_cyc [2][512];
    int         ren_q   [2][512];
    int         wen_n [2];
    int         wen_cyc [2][512];
    logic [7:0] wen_d   [2][512];
    logic [1:0] wen_q   [2][512];
    bit         bad [2];

    function automatic int enc(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        for (int u = 0; u < 2; u++) begin
            if (((ren_v[u] & empty_v[u]) != 4'b0) || ($countones(ren_v[u]) > 1)) bad[u] <= 1'b1;
            if (ren_v[u] != 4'b0 && ren_n[u] < 512) begin
                ren_cyc[u][ren_n[u]] <= cyc;
                ren_q[u][ren_n[u]]   <= enc(ren_v[u]);
                ren_n[u]             <= ren_n[u] + 1;
            end
            if (wen_v[u] && wen_n[u] < 512) begin
                wen_cyc[u][wen_n[u]] <= cyc;
                wen_d[u][wen_n[u]]   <= wdata_v[u];
                wen_q[u][wen_n[u]]   <= qid_v[u];
                wen_n[u]             <= wen_n[u] + 1;
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int u, input string tag);
        int n;
        n = 0;
        repeat (3) @(negedge clk_sys);
        while (busy_v[u] && n < 400) begin
            @(negedge clk_sys);
            n++;
        end
        chk(tag, int'(n < 400), 1);
    endtask

    task automatic wait_ren(input int u, input string tag);
        int n;
        n = 0;
        while (ren_v[u] == 4'b0 && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        chk(tag, int'(n < 100), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int b_r, b_w, q, n;
    int ord [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int st  [4] = '{10, 0, 0, 0};
`ifdef SFIFO_RR_SCH_WEIGHT_EN
    int wpat [6] = '{2, 2, 2, 3, 3, 0};
`endif

    initial begin
        reset      = 1'b1;
        afull_v[0] = 1'b0;
        afull_v[1] = 1'b0;
`ifdef SFIFO_RR_SCH_WEIGHT_EN
        cfg_weight = {8'd4, 8'd4, 8'd4, 8'd4};
`endif
        repeat (4) @(negedge clk_sys);
        chk("rst_ren",   ren_v[0],  0);
        chk("rst_wen",   wen_v[0],  0);
        chk("rst_wdata", wdata_v[0], 0);
        chk("rst_qid",   qid_v[0],  0);
        chk("rst_busy",  busy_v[0], 0);
        chk("rst_busy2", busy_v[1], 0);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);

        // Q0 alone with 10 words: bursts of 4,4,2 separated by one ARB cycle.
        b_r = ren_n[0]; b_w = wen_n[0];
        wr_cnt[0][0] += 10;
        wait_idle(0, "t1_idle");
        chk("t1_ren_n", ren_n[0] - b_r, 10);
        chk("t1_wen_n", wen_n[0] - b_w, 10);
        for (int k = 0; k < 10; k++) begin
            chk("t1_qid",  wen_q[0][b_w+k], 0);
            chk("t1_data", wen_d[0][b_w+k], k);
            chk("t1_lag",  wen_cyc[0][b_w+k] - ren_cyc[0][b_r+k], 1);
        end
        for (int k = 1; k < 10; k++)
            chk("t1_gap", ren_cyc[0][b_r+k] - ren_cyc[0][b_r+k-1], (k == 4 || k == 8) ? 2 : 1);

        // All queues with 8 words: grants 1,2,3,0 twice, 4 words each.
        b_r = ren_n[0]; b_w = wen_n[0];
        for (int i = 0; i < 4; i++) wr_cnt[0][i] += 8;
        wait_idle(0, "t2_idle");
        chk("t2_wen_n", wen_n[0] - b_w, 32);
        for (int j = 0; j < 32; j++) begin
            q = ord[j/4];
            chk("t2_qid",  wen_q[0][b_w+j], q);
            chk("t2_data", wen_d[0][b_w+j], q * 32 + st[q] + (j / 16) * 4 + (j % 4));
            if (j > 0) chk("t2_gap", ren_cyc[0][b_r+j] - ren_cyc[0][b_r+j-1], (j % 4 == 0) ? 2 : 1);
        end

        // Q3 single word: early exit, pointer lands on 3, so Q0 is next ahead of Q2.
        b_r = ren_n[0]; b_w = wen_n[0];
        wr_cnt[0][3] += 1;
        wait_idle(0, "t4_idle_a");
        chk("t4_ren_n", ren_n[0] - b_r, 1);
        chk("t4_data3", wen_d[0][b_w], 3 * 32 + 8);
        chk("t4_qid3",  wen_q[0][b_w], 3);
        b_r = ren_n[0]; b_w = wen_n[0];
        wr_cnt[0][0] += 1;
        wr_cnt[0][2] += 1;
        wait_idle(0, "t4_idle_b");
        chk("t4_first_q",  ren_q[0][b_r], 0);
        chk("t4_second_q", ren_q[0][b_r+1], 2);
        chk("t4_data0", wen_d[0][b_w], 18);
        chk("t4_data2", wen_d[0][b_w+1], 2 * 32 + 8);

        // RD_LAT=2 with a 5-cycle stall after the second read.
        b_r = ren_n[1]; b_w = wen_n[1];
        wr_cnt[1][2] += 3;
        wait_ren(1, "t3_start");
        @(negedge clk_sys);
        chk("t3_ren2", ren_v[1], 4);
        @(posedge clk_sys);
        #1 afull_v[1] = 1'b1;
        repeat (5) @(posedge clk_sys);
        #1 afull_v[1] = 1'b0;
        wait_idle(1, "t3_idle");
        chk("t3_ren_n", ren_n[1] - b_r, 3);
        chk("t3_wen_n", wen_n[1] - b_w, 3);
        chk("t3_gap1", ren_cyc[1][b_r+1] - ren_cyc[1][b_r], 1);
        chk("t3_gap2", ren_cyc[1][b_r+2] - ren_cyc[1][b_r+1], 6);
        for (int k = 0; k < 3; k++) begin
            chk("t3_lag",  wen_cyc[1][b_w+k] - ren_cyc[1][b_r+k], 2);
            chk("t3_data", wen_d[1][b_w+k], 2 * 32 + k);
            chk("t3_qid",  wen_q[1][b_w+k], 2);
        end

        // Reset on the edge that issues the first Q1 read: that word is lost.
        b_w = wen_n[0];
        wr_cnt[0][1] += 4;
        wait_ren(0, "t5_start");
        reset = 1'b1;
        @(negedge clk_sys);
        chk("t5_ren",   ren_v[0],  0);
        chk("t5_wen",   wen_v[0],  0);
        chk("t5_wdata", wdata_v[0], 0);
        chk("t5_qid",   qid_v[0],  0);
        chk("t5_busy",  busy_v[0], 0);
        reset = 1'b0;
        wait_idle(0, "t5_idle");
        chk("t5_wen_n", wen_n[0] - b_w, 3);
        for (int k = 0; k < 3; k++) begin
            chk("t5_data", wen_d[0][b_w+k], 32 + 9 + k);
            chk("t5_qid",  wen_q[0][b_w+k], 1);
        end

`ifdef SFIFO_RR_SCH_WEIGHT_EN
        // Weights Q0=1 Q1=0 Q2=3 Q3=2, pointer at 1: 2,2,2,3,3,0 repeating.
        b_w = wen_n[0];
        cfg_weight = {8'd2, 8'd3, 8'd0, 8'd1};
        for (int i = 0; i < 4; i++) wr_cnt[0][i] += 12;
        n = 0;
        while ((wen_n[0] - b_w) < 12 && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        chk("tw_timeout", int'(n < 200), 1);
        for (int j = 0; j < 12; j++) chk("tw_qid", wen_q[0][b_w+j], wpat[j % 6]);
`endif

        chk("no_bad_ren0", int'(bad[0]), 0);
        chk("no_bad_ren1", int'(bad[1]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sfifo_rr_sch.md
Name: sfifo_rr_sch

Overview:
- Round-robin read scheduler that drains QUEUE_NUM synchronous FIFOs (normal mode, non-ahead) into a single downstream write stream.
- Issues per-queue read enables and aligns the returned data with the FIFO read latency.
- Tags each output word with its source queue and honours a downstream almost-full stall.
- Sits between the per-channel FIFO bank and a shared egress FIFO or DMA engine.

Parameters:
- QUEUE_NUM, 4, number of source FIFOs (2..16).
- QID_W, 2, queue-id width; must equal ceil(log2(QUEUE_NUM)).
- DATA_W, 8, FIFO word width.
- RD_LAT, 1, FIFO read-data latency in cycles: 1 with no RAM output register, 2 with it.
- BURST_MAX, 4, maximum words read per grant before rotating (1..255).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fifo_empty  in  QUEUE_NUM  per-queue empty flag.
- fifo_ren  out  QUEUE_NUM  per-queue read enable; at most one bit high.
- fifo_rdata  in  QUEUE_NUM*DATA_W  per-queue read data; queue i occupies bits [i*DATA_W +: DATA_W].
- out_afull  in  1  downstream almost-full; stalls new reads.
- out_wen  out  1  downstream write strobe.
- out_wdata  out  DATA_W  downstream write data.
- out_qid  out  QID_W  source queue of out_wdata.
- sch_busy  out  1  high when the state is not IDLE or any read is in flight.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; grant pointer=0; burst count=0; all outputs 0.
- Reset mid-burst discards in-flight read returns; FIFO read pointers already advanced are not rewound.
- Request vector is ~fifo_empty.
- State IDLE:
  - If any request is pending and out_afull=0, go to ARB.
- State ARB (1 cycle):
  - Select the first requesting queue at or after ptr+1, modulo QUEUE_NUM.
  - Latch gnt_qid; clear burst count; go to BURST.
  - If no request is pending, return to IDLE.
- State BURST, each cycle:
  - fifo_ren[gnt_qid] = ~fifo_empty[gnt_qid] & ~out_afull.
  - Burst count increments on each issued read.
  - Leave BURST when the count reaches the limit (BURST_MAX, or the weight when the optional feature is enabled), or when the granted queue is empty with ren low.
  - On exit: ptr <= gnt_qid; go to ARB if any request is pending and out_afull=0, otherwise IDLE.
- out_afull=1 in BURST: hold the state and count; issue no reads; in-flight returns still complete.
- Downstream slack: it must absorb RD_LAT+1 writes after asserting out_afull.
- Read pipeline:
  - Issue {valid,qid} is shifted RD_LAT stages.
  - out_wen = valid at stage RD_LAT; out_qid = stage qid; out_wdata = fifo_rdata slice for stage qid.
  - out_wdata and out_qid are driven 0 when out_wen=0.
  - Throughput is one word per cycle within a burst.
  - Rotation overhead is 1 bubble cycle (ARB) per grant.
- Empty handling: the FIFO empty flag updates on the same edge as the read that empties it, so back-to-back reads never underflow. ren is never asserted while empty=1.
- Wrap-around: the pointer is modulo QUEUE_NUM; the queue after QUEUE_NUM-1 is queue 0.
- Single requester: re-granted after each burst; ARB bubble still inserted.
- Starvation bound: any non-empty queue is served within (QUEUE_NUM-1)*(BURST_MAX+1) issue cycles, excluding stall cycles.

Optional Feature:
- Macro: SFIFO_RR_SCH_WEIGHT_EN.
- Defined:
  - Adds input cfg_weight, width QUEUE_NUM*8; weight i is bits [i*8 +: 8].
  - The burst limit for queue i is cfg_weight[i], sampled in ARB.
  - Weight 0 means the queue is skipped by arbitration.
  - All weights 0 means the block stays in IDLE.
- Not defined: the port is absent and every limit equals BURST_MAX.

Decomposition:
- Shared package sfifo_sch_pkg:
  - state encoding constants ST_IDLE, ST_ARB, ST_BURST;
  - the clog2 function;
  - the default BURST_MAX constant.
- One natural sub-module, rr_arb_cbb: a combinational plus pointer round-robin picker taking the req vector and ptr, producing a one-hot grant and the encoded qid. It is reused by other schedulers.

Test Plan:
- Q0 holds 10 words, others empty, BURST_MAX=4, RD_LAT=1: reads come out 4,ARB,4,ARB,2. out_wdata is in FIFO order with qid=0, and out_wen lags ren by 1 cycle.
- All 4 queues hold 8 words: grant order 1,2,3,0,1,2,3,0 in bursts of 4. 32 words are delivered; each group of 4 shares one qid.
- RD_LAT=2, Q2 holds 3 words, out_afull raised on the 2nd ren cycle for 5 cycles: the 2 issued words arrive 2 cycles after their ren. No ren while stalled, then the 3rd word is read and the block returns to IDLE.
- Q3 holds 1 word at BURST_MAX=4: a single ren, early burst exit, ptr=3, next grant starts at Q0. fifo_ren never coincides with fifo_empty=1.
- reset asserted during BURST with 1 read in flight: next cycle all outputs are 0 and state is IDLE. The in-flight word is not emitted.
- With SFIFO_RR_SCH_WEIGHT_EN, weights {Q0=1,Q1=0,Q2=3,Q3=2}, all queues full: the repeating pattern is 0,2,2,2,3,3 and Q1 is never granted.
